// File: rtl/vga_text_pkg.sv
// Shared constants, state encoding and bus payload for the VGA text console writer.
package vga_text_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_CMD  = 4'd0;
  localparam logic [ADDR_W-1:0] REG_CHAR = 4'd1;
  localparam logic [ADDR_W-1:0] REG_X    = 4'd2;
  localparam logic [ADDR_W-1:0] REG_Y    = 4'd3;

  localparam logic [7:0] CMD_PUT   = 8'h01;
  localparam logic [7:0] CMD_CLEAR = 8'h02;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [3:0] {
    S_IDLE,
    S_POP,
    S_WR_CHAR,
    S_WR_X,
    S_WR_Y,
    S_WR_CMD,
    S_GUARD,
    S_POLL,
    S_ADV
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } vga_wr_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_char_fifo.sv
// Synchronous character FIFO with show-ahead read data, full/empty flags and fill count.
module vga_char_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  // a push into a full FIFO is only legal when the same cycle pops
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/vga_text_writer.sv
// Text console front end: buffers bytes, tracks the cursor and issues one peripheral command at a time.
module vga_text_writer
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic        busy,
  output logic        err,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        vga_wea,
  output logic [3:0]  vga_addra,
  output logic [31:0] vga_dina,
  input  logic [31:0] vga_douta
);

  localparam int unsigned PW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic [6:0]    x_q, x_d;
  logic [4:0]    y_q, y_d;
  logic [4:0]    y_inc;
  logic          err_q, err_d;
  logic [7:0]    ch_q, ch_d;
  logic          guard_q, guard_d;
  logic [PW-1:0] poll_q, poll_d;
  vga_wr_t       bus_q, bus_d;
  logic          is_bs;
  logic          pop_c;

  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          unused_douta;

  vga_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ch_valid && ch_ready),
    .din   (ch_data),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign is_bs = (ch_q == CH_BS);

  // next state, cursor and the bus word that the next state presents
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    ch_d    = ch_q;
    guard_d = guard_q;
    poll_d  = poll_q;
    pop_c   = 1'b0;
    bus_d   = '0;
    y_inc   = (y_q == 5'(ROWS - 1)) ? 5'd0 : y_q + 5'd1;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          ch_d    = fifo_dout;
          state_d = S_POP;
        end
      end
      S_POP: begin
        if (is_printable(ch_q) || (is_bs && x_q != 7'd0)) begin
          state_d = S_WR_CHAR;
        end else if (ch_q == CH_FF) begin
          x_d     = '0;
          y_d     = '0;
          state_d = S_WR_CMD;
        end else if (ch_q == CH_LF) begin
          x_d     = '0;
          y_d     = y_inc;
          state_d = S_IDLE;
        end else if (ch_q == CH_CR) begin
          x_d     = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_CHAR: state_d = S_WR_X;
      S_WR_X:    state_d = S_WR_Y;
      S_WR_Y:    state_d = S_WR_CMD;
      S_WR_CMD: begin
        guard_d = 1'b0;
        state_d = S_GUARD;
      end
      S_GUARD: begin
        if (guard_q) begin
          poll_d  = '0;
          state_d = S_POLL;
        end else begin
          guard_d = 1'b1;
        end
      end
      S_POLL: begin
        if (vga_douta[0]) begin
          state_d = S_ADV;
        end else if (poll_q == PW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          poll_d = poll_q + PW'(1);
        end
      end
      S_ADV: begin
        if (is_bs) begin
          x_d = x_q - 7'd1;
        end else if (ch_q != CH_FF) begin
          if (x_q == 7'(COLS - 1)) begin
            x_d = '0;
            y_d = y_inc;
          end else begin
            x_d = x_q + 7'd1;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_WR_CHAR: begin
        bus_d.we   = 1'b1;
        bus_d.addr = REG_CHAR;
        bus_d.data = 32'(is_bs ? CH_SPACE : ch_q);
      end
      S_WR_X: begin
        bus_d.we   = 1'b1;
        bus_d.addr = REG_X;
        bus_d.data = 32'(is_bs ? x_q - 7'd1 : x_q);
      end
      S_WR_Y: begin
        bus_d.we   = 1'b1;
        bus_d.addr = REG_Y;
        bus_d.data = 32'(y_q);
      end
      S_WR_CMD: begin
        bus_d.we   = 1'b1;
        bus_d.addr = REG_CMD;
        bus_d.data = 32'((ch_q == CH_FF) ? CMD_CLEAR : CMD_PUT);
      end
      default: bus_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      ch_q    <= '0;
      guard_q <= 1'b0;
      poll_q  <= '0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      ch_q    <= ch_d;
      guard_q <= guard_d;
      poll_q  <= poll_d;
      bus_q   <= bus_d;
    end
  end

  assign ch_ready     = !fifo_full;
  assign busy         = (state_q != S_IDLE) || (fifo_count != '0);
  assign err          = err_q;
  assign cur_x        = x_q;
  assign cur_y        = y_q;
  assign vga_wea      = bus_q.we;
  assign vga_addra    = bus_q.addr;
  assign vga_dina     = bus_q.data;
  // only the idle bit of the status register matters here
  assign unused_douta = ^vga_douta[31:1];

endmodule

// File: tb/tb_vga_text_writer.sv
// Randomized scoreboard bench for vga_text_writer with a linear-position cursor model.
module tb_vga_text_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int DEPTH = 16;
  localparam int TMO   = 40;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        chained;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        busy;
  logic        err;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        vga_wea;
  logic [3:0]  vga_addra;
  logic [31:0] vga_dina;
  logic [31:0] vga_douta = 32'd0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_wr = -100;
  int   pbusy = 0;
  bit   stall = 1'b0;
  int   mpos = 0;
  exp_t exp_q[$];

  vga_text_writer #(
    .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_ready  (ch_ready),
    .busy      (busy),
    .err       (err),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .vga_wea   (vga_wea),
    .vga_addra (vga_addra),
    .vga_dina  (vga_dina),
    .vga_douta (vga_douta)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // peripheral: a command keeps it busy for a random time, or forever while stalled
  always @(posedge clk) begin
    if (pbusy > 0) pbusy <= pbusy - 1;
    if (vga_wea && vga_addra == 4'd0) pbusy <= int'($urandom_range(0, 8));
    vga_douta <= (vga_addra == 4'd0) ? {31'd0, (pbusy == 0) && !stall} : 32'd0;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && vga_wea) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%0d data=%h required none", vga_addra, vga_dina);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (vga_addra !== e.addr || vga_dina !== e.data) begin
          errors++;
          $display("FAIL bus_write actual (%0d,%h) required (%0d,%h)", vga_addra, vga_dina, e.addr, e.data);
        end
        checks++;
        if (e.chained ? (cyc != last_wr + 1) : (cyc <= last_wr + 1)) begin
          errors++;
          $display("FAIL write_spacing actual gap=%0d chained=%0d", cyc - last_wr, e.chained);
        end
      end
      last_wr = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic put_char(input int ch, input int x, input int y);
    exp_q.push_back('{4'd1, 32'(ch), 1'b0});
    exp_q.push_back('{4'd2, 32'(x), 1'b1});
    exp_q.push_back('{4'd3, 32'(y), 1'b1});
    exp_q.push_back('{4'd0, 32'h1, 1'b1});
  endtask

  // reference model on a linear screen position
  task automatic model_byte(input logic [7:0] b);
    int x, y;
    x = mpos % COLS;
    y = mpos / COLS;
    if (b >= 8'h20 && b <= 8'h7E) begin
      put_char(int'(b), x, y);
      if (!stall) mpos = (mpos + 1) % (COLS * ROWS);
    end else if (b == 8'h08) begin
      if (x > 0) begin
        put_char(32, x - 1, y);
        if (!stall) mpos = mpos - 1;
      end
    end else if (b == 8'h0C) begin
      exp_q.push_back('{4'd0, 32'h2, 1'b0});
      mpos = 0;
    end else if (b == 8'h0A) begin
      mpos = ((y + 1) % ROWS) * COLS;
    end else if (b == 8'h0D) begin
      mpos = mpos - x;
    end
  endtask

  // called at a negedge; returns at the negedge after the transfer
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    while (!ch_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ch_ready) begin
      errors++;
      checks++;
      $display("FAIL push_timeout actual ch_ready=0 required 1");
    end else begin
      ch_valid = 1'b1;
      ch_data  = b;
      model_byte(b);
      @(negedge clk);
      ch_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      errors++;
      checks++;
      $display("FAIL idle_timeout actual busy=1 required 0 after %0d cycles", budget);
    end
    chk("pending_writes", exp_q.size(), 0);
  endtask

  task automatic chk_cursor(input string name);
    chk({name, "_x"}, int'(cur_x), mpos % COLS);
    chk({name, "_y"}, int'(cur_y), mpos / COLS);
  endtask

  task automatic rand_byte(output logic [7:0] b);
    case ($urandom_range(0, 9))
      6:       b = 8'h08;
      7:       b = 8'h0D;
      8:       b = 8'h0A;
      9:       b = 8'($urandom_range(0, 255));
      default: b = 8'($urandom_range(32, 126));
    endcase
  endtask

  initial begin
    logic [7:0] b;
    int t0, n;
    rst = 1'b1;
    ch_valid = 1'b0;
    ch_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_wea", int'(vga_wea), 0);
    chk("rst_addra", int'(vga_addra), 0);
    chk("rst_dina", int'(vga_dina), 0);
    chk("rst_cur_x", int'(cur_x), 0);
    chk("rst_cur_y", int'(cur_y), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ch_ready", int'(ch_ready), 1);

    // single printable character
    push_byte(8'h41);
    wait_idle(200);
    chk("t1_cur_x", int'(cur_x), 1);
    chk("t1_cur_y", int'(cur_y), 0);
    chk("t1_busy", int'(busy), 0);

    // walk to the last cell, then wrap the whole screen
    push_byte(8'h0C);
    for (int i = 0; i < ROWS - 1; i++) push_byte(8'h0A);
    for (int i = 0; i < COLS - 1; i++) push_byte(8'($urandom_range(32, 126)));
    wait_idle(5000);
    chk("t2_pre_x", int'(cur_x), 79);
    chk("t2_pre_y", int'(cur_y), 29);
    push_byte(8'h5A);
    wait_idle(200);
    chk("t2_wrap_x", int'(cur_x), 0);
    chk("t2_wrap_y", int'(cur_y), 0);

    // CR/LF/BS handling
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h0D);
    push_byte(8'h0A);
    push_byte(8'h08);
    wait_idle(500);
    chk("t3_crlf_x", int'(cur_x), 0);
    chk("t3_crlf_y", int'(cur_y), 1);
    push_byte(8'h43);
    push_byte(8'h08);
    wait_idle(500);
    chk("t3_bs_x", int'(cur_x), 0);
    chk("t3_bs_y", int'(cur_y), 1);

    // clear screen
    push_byte(8'h0C);
    wait_idle(200);
    chk("t4_x", int'(cur_x), 0);
    chk("t4_y", int'(cur_y), 0);

    // random stream with idle gaps
    for (int i = 0; i < 80; i++) begin
      rand_byte(b);
      push_byte(b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    wait_idle(5000);
    chk_cursor("rand");
    chk("rand_err", int'(err), 0);

    // stalled peripheral: FIFO fills, commands time out
    stall = 1'b1;
    t0 = cyc;
    push_byte(8'($urandom_range(32, 126)));
    for (int i = 0; i < DEPTH; i++) begin
      rand_byte(b);
      push_byte(b);
    end
    chk("t5_push_cycles", cyc - t0, DEPTH + 1);
    chk("t5_ch_ready", int'(ch_ready), 0);
    chk("t5_busy", int'(busy), 1);
    n = 0;
    while (err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_err", int'(err), 1);
    wait_idle((DEPTH + 1) * (TMO + 20));
    chk_cursor("t5");
    chk("t5_err_sticky", int'(err), 1);

    // reset during POLL
    push_byte(8'h51);
    push_byte(8'h52);
    push_byte(8'h53);
    n = 0;
    while (!(vga_wea && vga_addra == 4'd0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_cmd_seen", int'(vga_wea && vga_addra == 4'd0), 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mpos = 0;
    stall = 1'b0;
    chk("t6_wea", int'(vga_wea), 0);
    chk("t6_cur_x", int'(cur_x), 0);
    chk("t6_cur_y", int'(cur_y), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_err", int'(err), 0);
    chk("t6_ch_ready", int'(ch_ready), 1);
    repeat (30) @(negedge clk);
    chk("t6_quiet_busy", int'(busy), 0);

    // normal operation after reset
    push_byte(8'h41);
    wait_idle(200);
    chk("post_cur_x", int'(cur_x), 1);
    chk("post_cur_y", int'(cur_y), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1);
  end

endmodule
